ram_access_ctrl: RTL and testbench

Initiator-side controller for the byte-oriented, big-endian 64-bit test RAM. It accepts load/store requests of 1/2/4/8 bytes from the CPU load/store path and drives the RAM's cs/we/addr/data_in. It consumes the RAM's 1-cycle registered read data and performs read-modify-write for sub-doubleword stores, because the RAM always writes 8 bytes. It returns right-justified, optionally sign-extended load data.

---
 rtl/ram_access_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ram_access_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// Initiator-side controller for the byte-addressed, big-endian 64-bit test RAM:
// 1/2/4/8-byte loads and stores, read-modify-write for sub-dword stores.
// Optional range check: define RAM_ACCESS_CTRL_BOUNDS_CHECK_EN.
module ram_access_ctrl #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_WRITE,
        S_RESP
    } state_e;

    state_e      state_q;
    logic        we_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [63:0] wdata_q;

    logic        req_ready_q;
    logic        resp_valid_q;
    logic [63:0] resp_rdata_q;
    logic        resp_err_q;
    logic        mem_cs_q;
    logic        mem_we_q;
    logic [63:0] mem_addr_q;
    logic [63:0] mem_wdata_q;

    logic [2:0]  nbm1_d;
    logic [5:0]  shamt_d;
    logic [63:0] top_mask_d;
    logic [63:0] low_mask_d;
    logic [63:0] load_data_d;
    logic [63:0] merged_d;
    logic        oob_d;

    if (MEM_BYTES < 8) begin : g_bad_mem_bytes
        $error("ram_access_ctrl: MEM_BYTES must be at least 8");
    end

    // The RAM returns the N addressed bytes in the top of the word; shamt is 64-8N.
    always_comb begin
        nbm1_d = 3'd0;
        unique case (size_q)
            2'd0: nbm1_d = 3'd0;
            2'd1: nbm1_d = 3'd1;
            2'd2: nbm1_d = 3'd3;
            2'd3: nbm1_d = 3'd7;
        endcase
        shamt_d     = {3'd7 - nbm1_d, 3'b000};
        top_mask_d  = ~64'd0 << shamt_d;
        low_mask_d  = ~64'd0 >> shamt_d;
        load_data_d = mem_rdata >> shamt_d;
        if (signed_q && mem_rdata[63]) begin
            load_data_d = load_data_d | ~low_mask_d;
        end
        merged_d = (mem_rdata & ~top_mask_d) | ((wdata_q << shamt_d) & top_mask_d);
`ifdef RAM_ACCESS_CTRL_BOUNDS_CHECK_EN
        oob_d = ({1'b0, req_addr} + 65'd8) > 65'(MEM_BYTES);
`else
        oob_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= 2'd0;
            wdata_q      <= 64'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
            mem_cs_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 64'd0;
            mem_wdata_q  <= 64'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        we_q        <= req_we;
                        signed_q    <= req_signed;
                        size_q      <= req_size;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (oob_d) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 64'd0;
                        end else begin
                            // A full dword store needs no read: write straight away.
                            state_q     <= S_ISSUE;
                            mem_cs_q    <= 1'b1;
                            mem_addr_q  <= req_addr;
                            mem_we_q    <= req_we && (req_size == 2'd3);
                            mem_wdata_q <= (req_we && (req_size == 2'd3)) ? req_wdata : 64'd0;
                        end
                    end
                end
                S_ISSUE: begin
                    mem_cs_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_wdata_q <= 64'd0;
                    if (we_q && (size_q == 2'd3)) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= 64'd0;
                        resp_err_q   <= 1'b0;
                    end else begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (we_q) begin
                        state_q     <= S_WRITE;
                        mem_cs_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merged_d;
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_data_d;
                        resp_err_q   <= 1'b0;
                    end
                end
                S_WRITE: begin
                    state_q      <= S_RESP;
                    mem_cs_q     <= 1'b0;
                    mem_we_q     <= 1'b0;
                    mem_wdata_q  <= 64'd0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= 64'd0;
                    resp_err_q   <= 1'b0;
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_cs     = mem_cs_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural byte-addressed,
// big-endian RAM (1-cycle registered read) attached.
module tb_ram_access_ctrl;

    localparam int MEMB = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_cs;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'd0;

    logic        ram_init = 1'b1;
    logic [7:0]  ram [0:MEMB+7];

    int          cs_cnt = 0;
    int          we_cnt = 0;
    int          rv_cnt = 0;
    int          wd_viol = 0;
    logic [63:0] last_wd = 64'd0;

    int          n_cmp = 0;
    int          n_bad = 0;

    ram_access_ctrl #(.MEM_BYTES(MEMB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: bytes 0x10..0x17 = 11 22 .. 88, all else 0.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < MEMB + 8; i++) begin
                ram[i] <= (i >= 16 && i < 24) ? 8'(17 * (i - 15)) : 8'h00;
            end
        end else if (mem_cs) begin
            for (int i = 0; i < 8; i++) begin
                if (mem_we) ram[int'(mem_addr[7:0]) + i] <= mem_wdata[63-8*i -: 8];
                else        mem_rdata[63-8*i -: 8] <= ram[int'(mem_addr[7:0]) + i];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_cs) cs_cnt <= cs_cnt + 1;
        if (mem_we) begin
            we_cnt  <= we_cnt + 1;
            last_wd <= mem_wdata;
        end
        if (resp_valid) rv_cnt <= rv_cnt + 1;
        if (!mem_we && mem_wdata != 64'd0) wd_viol <= wd_viol + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          output int lat, output logic [63:0] rd, output logic err,
                          output int ncs, output int nwe);
        int t;
        int cs0;
        int we0;
        @(negedge clk);
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        cs0 = cs_cnt; we0 = we_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rd = 'x; err = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k; rd = resp_rdata; err = resp_err;
                break;
            end
        end
        ncs = cs_cnt - cs0;
        nwe = we_cnt - we0;
        $display("txn we=%0b size=%0d signed=%0b addr=0x%0h wdata=0x%016h -> lat=%0d rdata=0x%016h err=%0b cs=%0d we=%0d",
                 we, size, sgn, addr, wdata, lat, rd, err, ncs, nwe);
    endtask

    initial begin
        int          lat;
        logic [63:0] rd;
        logic        err;
        int          ncs;
        int          nwe;
        int          we0;
        int          rv0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ram_init = 1'b0;
        @(negedge clk);
        check("reset req_ready",  64'(req_ready), 64'd1);
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset resp_rdata", resp_rdata, 64'd0);
        check("reset mem_cs/we",  {62'd0, mem_cs, mem_we}, 64'd0);
        check("reset mem_addr",   mem_addr, 64'd0);

        // 1: dword load
        do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, lat, rd, err, ncs, nwe);
        check("ld64 data", rd, 64'h1122334455667788);
        check("ld64 lat",  64'(lat), 64'd3);
        check("ld64 cs",   64'(ncs), 64'd1);
        check("ld64 we",   64'(nwe), 64'd0);
        check("ld64 err",  64'(err), 64'd0);

        // 2: narrow loads, extension
        do_req(1'b0, 2'd0, 1'b1, 64'h17, 64'd0, lat, rd, err, ncs, nwe);
        check("ld8 signed", rd, 64'hFFFFFFFFFFFFFF88);
        do_req(1'b0, 2'd0, 1'b0, 64'h17, 64'd0, lat, rd, err, ncs, nwe);
        check("ld8 unsigned", rd, 64'h0000000000000088);
        check("ld8 lat", 64'(lat), 64'd3);
        do_req(1'b0, 2'd1, 1'b1, 64'h16, 64'd0, lat, rd, err, ncs, nwe);
        check("ld16 signed positive", rd, 64'h0000000000007788);
        do_req(1'b0, 2'd2, 1'b0, 64'h13, 64'd0, lat, rd, err, ncs, nwe);
        check("ld32 unsigned", rd, 64'h0000000044556677);
        repeat (3) @(negedge clk);
        check("resp_rdata hold", resp_rdata, 64'h0000000044556677);

        // 3: half store, read-modify-write of bytes 0x12..0x19
        do_req(1'b1, 2'd1, 1'b0, 64'h12, 64'h000000000000BEEF, lat, rd, err, ncs, nwe);
        check("st16 lat",   64'(lat), 64'd4);
        check("st16 cs",    64'(ncs), 64'd2);
        check("st16 we",    64'(nwe), 64'd1);
        check("st16 wdata", last_wd, 64'hBEEF556677880000);
        check("st16 rdata", rd, 64'd0);
        do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, lat, rd, err, ncs, nwe);
        check("ld64 after st16", rd, 64'h1122BEEF55667788);

        // 4: dword store, single write cycle
        do_req(1'b1, 2'd3, 1'b0, 64'h20, 64'hDEADBEEFCAFEF00D, lat, rd, err, ncs, nwe);
        check("st64 lat",   64'(lat), 64'd2);
        check("st64 cs",    64'(ncs), 64'd1);
        check("st64 we",    64'(nwe), 64'd1);
        check("st64 wdata", last_wd, 64'hDEADBEEFCAFEF00D);
        check("st64 rdata", rd, 64'd0);
        do_req(1'b0, 2'd3, 1'b0, 64'h20, 64'd0, lat, rd, err, ncs, nwe);
        check("ld64 after st64", rd, 64'hDEADBEEFCAFEF00D);

        // 5: byte store abandoned by reset during CAPTURE
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 64'h10; req_wdata = 64'hAA; req_valid = 1'b1;
        we0 = we_cnt; rv0 = rv_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("txn st8 0xAA @0x10 with reset in CAPTURE");
        check("rst mid req_ready",  64'(req_ready), 64'd1);
        check("rst mid outputs",    {61'd0, resp_valid, mem_cs, mem_we}, 64'd0);
        check("rst mid resp_rdata", resp_rdata, 64'd0);
        check("rst mid mem_addr",   mem_addr, 64'd0);
        check("rst mid mem_wdata",  mem_wdata, 64'd0);
        repeat (3) @(negedge clk);
        check("rst mid no write", 64'(we_cnt - we0), 64'd0);
        check("rst mid no resp",  64'(rv_cnt - rv0), 64'd0);
        check("rst mid ram[0x10]", 64'(ram[16]), 64'h11);
        do_req(1'b0, 2'd0, 1'b0, 64'h10, 64'd0, lat, rd, err, ncs, nwe);
        check("ld8 after abort", rd, 64'h11);

`ifdef RAM_ACCESS_CTRL_BOUNDS_CHECK_EN
        // 6: range check at the top of a 256-byte RAM
        do_req(1'b0, 2'd0, 1'b0, 64'hF9, 64'd0, lat, rd, err, ncs, nwe);
        check("oob err",   64'(err), 64'd1);
        check("oob rdata", rd, 64'd0);
        check("oob cs",    64'(ncs), 64'd0);
        check("oob lat",   64'(lat), 64'd1);
        do_req(1'b0, 2'd3, 1'b0, 64'hF8, 64'd0, lat, rd, err, ncs, nwe);
        check("edge err",  64'(err), 64'd0);
        check("edge lat",  64'(lat), 64'd3);
        check("edge cs",   64'(ncs), 64'd1);
        check("edge rdata", rd, 64'd0);
`endif

        check("mem_wdata zero when not writing", 64'(wd_viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
